stream_mux_rr: RTL

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshaking on every input and on the output. It is the successor to the 8-bit 4:1 combinational mux. It adds two selection modes: direct select (as before) and round-robin arbitration. The output stage is registered and carries the source channel index. It sits between multiple producer streams and a single consumer.

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/stream_mux_rr.sv | 72 +++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and defaults for the registered round-robin stream multiplexer.
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    localparam int MUX_WIDTH    = 8;
    localparam int MUX_CHANNELS = 4;

    // Channel index reached by stepping 'off' places upward from 'base', wrapping at n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above rr_ptr (wrapping)
// and moves the pointer past the winner when the grant is consumed.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = MUX_CHANNELS,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx
);

    logic [SEL_W-1:0] rr_ptr;
    logic             found;
    int               idx;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = wrap_idx(int'(rr_ptr), i, CHANNELS);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with direct-select or round-robin
// selection feeding a single registered output stage tagged with its source channel.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH    = MUX_WIDTH,
    parameter  int CHANNELS = MUX_CHANNELS,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    mux_mode_e           mode_e;
    logic [CHANNELS-1:0] rr_grant;
    logic [SEL_W-1:0]    rr_idx;
    logic [CHANNELS-1:0] sel_grant;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                accept_ok;
    logic                accept;

    assign mode_e = mux_mode_e'(mode);

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .advance   (accept && (mode_e == MODE_RR)),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    // Out-of-range selects (non-power-of-2 channel counts) grant nothing.
    always_comb begin
        sel_grant = '0;
        if (int'(sel) < CHANNELS) begin
            sel_grant[sel] = in_valid[sel];
        end
    end

    assign grant     = (mode_e == MODE_RR) ? rr_grant : sel_grant;
    assign grant_idx = (mode_e == MODE_RR) ? rr_idx   : sel;
    assign accept_ok = !out_valid || out_ready;
    assign in_ready  = grant & {CHANNELS{accept_ok && rst_n}};
    assign accept    = |in_ready;

    // NOTE: the datapath register is reset as well, because out_data/out_chan must read zero while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= in_data[grant_idx*WIDTH +: WIDTH];
            out_chan  <= grant_idx;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
